// File: rtl/mips_mc_pkg.sv
// rtl/mips_mc_pkg.sv - shared constants for the multicycle MIPS main control and ALUcontrol
//
// Purpose: state encodings, opcode constants, ALUOp / ALUSrcB / PCSource codes and the
//          DECODE dispatch helpers used by multicycle_main_control (and by ALUcontrol for ALUOp).
// Ports:   none (package).
// Config:  MEM_WAIT_EN is not referenced here; see multicycle_main_control.

package mips_mc_pkg;

  localparam int STATE_BITS = 4;

  typedef enum logic [STATE_BITS-1:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_RTYPE_EX = 4'd6,
    S_RTYPE_WB = 4'd7,
    S_BEQ_EX   = 4'd8,
    S_ADDI_EX  = 4'd9,
    S_ADDI_WB  = 4'd10,
    S_JUMP     = 4'd11
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  function automatic logic op_is_legal(input logic [5:0] op);
    case (op)
      OP_RTYPE, OP_J, OP_BEQ, OP_ADDI, OP_LW, OP_SW: op_is_legal = 1'b1;
      default:                                       op_is_legal = 1'b0;
    endcase
  endfunction

  // Successor of DECODE; unsupported opcodes return to FETCH.
  function automatic state_e decode_next(input logic [5:0] op);
    case (op)
      OP_LW, OP_SW: decode_next = S_MEMADR;
      OP_RTYPE:     decode_next = S_RTYPE_EX;
      OP_BEQ:       decode_next = S_BEQ_EX;
      OP_ADDI:      decode_next = S_ADDI_EX;
      OP_J:         decode_next = S_JUMP;
      default:      decode_next = S_FETCH;
    endcase
  endfunction

endpackage

// File: rtl/mc_mem_wait_counter.sv
// rtl/mc_mem_wait_counter.sv - memory wait-cycle counter with expiry at WAIT_MAX hold cycles
//
// Purpose: counts consecutive cycles the sequencer holds waiting for memory; oExpire flags
//          the WAIT_MAX-th hold cycle. Used only in MEM_WAIT_EN builds.
// Ports:   iClk     in  clock
//          iReset   in  synchronous active-high reset
//          iClear   in  restart count (not waiting, or memory ready)
//          iEnable  in  this cycle is a hold cycle
//          oExpire  out current hold cycle is the WAIT_MAX-th one

module mc_mem_wait_counter #(
  parameter int WAIT_MAX = 15
) (
  input  logic iClk,
  input  logic iReset,
  input  logic iClear,
  input  logic iEnable,
  output logic oExpire
);

  localparam int CNT_W = $clog2(WAIT_MAX + 1);

  logic [CNT_W-1:0] count_q;

  // count_q holds the number of hold cycles already completed.
  assign oExpire = iEnable && (count_q == CNT_W'(WAIT_MAX - 1));

  always_ff @(posedge iClk) begin
    if (iReset || iClear || oExpire) begin
      count_q <= '0;
    end else if (iEnable) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/multicycle_main_control.sv
// rtl/multicycle_main_control.sv - Moore main sequencer of the multicycle MIPS datapath
//
// Purpose: steps PC, memory, IR, register file and ALU through fetch/decode/execute/mem/
//          writeback, one instruction at a time. Optional macro: MEM_WAIT_EN (memory
//          handshake via iMemReady with wait timeout oMemTimeout).
// Ports:   iClk, iReset (sync active-high), iOpcode[5:0] (sampled in DECODE),
//          iMemReady (MEM_WAIT_EN only),
//          oPCWrite, oPCWriteCond, oIorD, oMemRead, oMemWrite, oIRWrite, oMemtoReg,
//          oRegWrite, oRegDst, oALUSrcA, oALUSrcB[1:0], oPCSource[1:0], oALUOp[1:0],
//          oInstrDone, oIllegal, oMemTimeout (MEM_WAIT_EN only), oState[STATE_W-1:0].

module multicycle_main_control
  import mips_mc_pkg::*;
#(
  parameter int STATE_W = 4
`ifdef MEM_WAIT_EN
  , parameter int WAIT_MAX = 15
`endif
) (
  input  logic               iClk,
  input  logic               iReset,
  input  logic [5:0]         iOpcode,
`ifdef MEM_WAIT_EN
  input  logic               iMemReady,
  output logic               oMemTimeout,
`endif
  output logic               oPCWrite,
  output logic               oPCWriteCond,
  output logic               oIorD,
  output logic               oMemRead,
  output logic               oMemWrite,
  output logic               oIRWrite,
  output logic               oMemtoReg,
  output logic               oRegWrite,
  output logic               oRegDst,
  output logic               oALUSrcA,
  output logic [1:0]         oALUSrcB,
  output logic [1:0]         oPCSource,
  output logic [1:0]         oALUOp,
  output logic               oInstrDone,
  output logic               oIllegal,
  output logic [STATE_W-1:0] oState
);

  state_e state_q;
  logic   is_sw_q;     // lw/sw choice captured in DECODE, used by MEMADR
  logic   mem_ready;
  logic   wait_expire;

`ifdef MEM_WAIT_EN
  logic timeout_q;
  logic wait_state;

  assign mem_ready  = iMemReady;
  assign wait_state = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);

  mc_mem_wait_counter #(
    .WAIT_MAX (WAIT_MAX)
  ) u_wait_cnt (
    .iClk    (iClk),
    .iReset  (iReset),
    .iClear  (!wait_state || iMemReady),
    .iEnable (wait_state && !iMemReady),
    .oExpire (wait_expire)
  );

  assign oMemTimeout = timeout_q && !iReset;
`else
  // Single-cycle memory: every access completes in the cycle it is issued.
  assign mem_ready   = 1'b1;
  assign wait_expire = 1'b0;
`endif

  always_ff @(posedge iClk) begin
    if (iReset) begin
      state_q <= S_FETCH;
      is_sw_q <= 1'b0;
`ifdef MEM_WAIT_EN
      timeout_q <= 1'b0;
`endif
    end else if (wait_expire) begin
      // Memory never answered: abandon the instruction and restart at FETCH.
      state_q <= S_FETCH;
`ifdef MEM_WAIT_EN
      timeout_q <= 1'b1;
`endif
    end else begin
      case (state_q)
        S_FETCH:    if (mem_ready) state_q <= S_DECODE;
        S_DECODE: begin
          is_sw_q <= (iOpcode == OP_SW);
          state_q <= decode_next(iOpcode);
        end
        S_MEMADR:   state_q <= is_sw_q ? S_MEMWR : S_MEMRD;
        S_MEMRD:    if (mem_ready) state_q <= S_MEMWB;
        S_MEMWR:    if (mem_ready) state_q <= S_FETCH;
        S_RTYPE_EX: state_q <= S_RTYPE_WB;
        S_ADDI_EX:  state_q <= S_ADDI_WB;
        default:    state_q <= S_FETCH;  // terminal states and unused encodings
      endcase
    end
  end

  // Outputs decode state_q only, except oIllegal (opcode in DECODE) and the memory
  // handshake gating; reset forces everything to 0.
  always_comb begin
    oPCWrite     = 1'b0;
    oPCWriteCond = 1'b0;
    oIorD        = 1'b0;
    oMemRead     = 1'b0;
    oMemWrite    = 1'b0;
    oIRWrite     = 1'b0;
    oMemtoReg    = 1'b0;
    oRegWrite    = 1'b0;
    oRegDst      = 1'b0;
    oALUSrcA     = 1'b0;
    oALUSrcB     = SRCB_B;
    oPCSource    = PCSRC_ALU;
    oALUOp       = ALUOP_ADD;
    oInstrDone   = 1'b0;
    oIllegal     = 1'b0;
    case (state_q)
      S_FETCH: begin
        oMemRead = 1'b1;
        oIRWrite = mem_ready;
        oPCWrite = mem_ready;
        oALUSrcB = SRCB_FOUR;
      end
      S_DECODE: begin
        oALUSrcB = SRCB_IMM_SH2;
        oIllegal = !op_is_legal(iOpcode);
      end
      S_MEMADR, S_ADDI_EX: begin
        oALUSrcA = 1'b1;
        oALUSrcB = SRCB_IMM;
      end
      S_MEMRD: begin
        oMemRead = 1'b1;
        oIorD    = 1'b1;
      end
      S_MEMWB: begin
        oRegWrite  = 1'b1;
        oMemtoReg  = 1'b1;
        oInstrDone = 1'b1;
      end
      S_MEMWR: begin
        oMemWrite  = 1'b1;
        oIorD      = 1'b1;
        oInstrDone = mem_ready;
      end
      S_RTYPE_EX: begin
        oALUSrcA = 1'b1;
        oALUOp   = ALUOP_FUNCT;
      end
      S_RTYPE_WB: begin
        oRegWrite  = 1'b1;
        oRegDst    = 1'b1;
        oInstrDone = 1'b1;
      end
      S_BEQ_EX: begin
        oALUSrcA     = 1'b1;
        oALUOp       = ALUOP_SUB;
        oPCWriteCond = 1'b1;
        oPCSource    = PCSRC_ALUOUT;
        oInstrDone   = 1'b1;
      end
      S_ADDI_WB: begin
        oRegWrite  = 1'b1;
        oInstrDone = 1'b1;
      end
      S_JUMP: begin
        oPCWrite   = 1'b1;
        oPCSource  = PCSRC_JUMP;
        oInstrDone = 1'b1;
      end
      default: ;
    endcase
    if (iReset) begin
      oPCWrite     = 1'b0;
      oPCWriteCond = 1'b0;
      oIorD        = 1'b0;
      oMemRead     = 1'b0;
      oMemWrite    = 1'b0;
      oIRWrite     = 1'b0;
      oMemtoReg    = 1'b0;
      oRegWrite    = 1'b0;
      oRegDst      = 1'b0;
      oALUSrcA     = 1'b0;
      oALUSrcB     = SRCB_B;
      oPCSource    = PCSRC_ALU;
      oALUOp       = ALUOP_ADD;
      oInstrDone   = 1'b0;
      oIllegal     = 1'b0;
    end
  end

  assign oState = STATE_W'(state_q);

endmodule

// File: tb/tb_multicycle_main_control.sv
// tb/tb_multicycle_main_control.sv - directed self-checking bench for multicycle_main_control

module tb_multicycle_main_control;
  import mips_mc_pkg::*;

  logic       iClk = 1'b0;
  logic       iReset;
  logic [5:0] iOpcode;
  logic       oPCWrite, oPCWriteCond, oIorD, oMemRead, oMemWrite, oIRWrite;
  logic       oMemtoReg, oRegWrite, oRegDst, oALUSrcA, oInstrDone, oIllegal;
  logic [1:0] oALUSrcB, oPCSource, oALUOp;
  logic [3:0] oState;
`ifdef MEM_WAIT_EN
  logic       iMemReady;
  logic       oMemTimeout;
`endif

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  always #5 iClk = ~iClk;

  multicycle_main_control dut (
    .iClk         (iClk),
    .iReset       (iReset),
    .iOpcode      (iOpcode),
`ifdef MEM_WAIT_EN
    .iMemReady    (iMemReady),
    .oMemTimeout  (oMemTimeout),
`endif
    .oPCWrite     (oPCWrite),
    .oPCWriteCond (oPCWriteCond),
    .oIorD        (oIorD),
    .oMemRead     (oMemRead),
    .oMemWrite    (oMemWrite),
    .oIRWrite     (oIRWrite),
    .oMemtoReg    (oMemtoReg),
    .oRegWrite    (oRegWrite),
    .oRegDst      (oRegDst),
    .oALUSrcA     (oALUSrcA),
    .oALUSrcB     (oALUSrcB),
    .oPCSource    (oPCSource),
    .oALUOp       (oALUOp),
    .oInstrDone   (oInstrDone),
    .oIllegal     (oIllegal),
    .oState       (oState)
  );

  // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,MemtoReg,RegWrite,RegDst,SrcA,SrcB,PCSource,ALUOp,Done,Illegal}
  logic [17:0] ctrl_obs;
  assign ctrl_obs = {oPCWrite, oPCWriteCond, oIorD, oMemRead, oMemWrite, oIRWrite, oMemtoReg,
                     oRegWrite, oRegDst, oALUSrcA, oALUSrcB, oPCSource, oALUOp, oInstrDone, oIllegal};

  localparam logic [17:0] C_ZERO     = 18'b0_0_0_0_0_0_0_0_0_0_00_00_00_0_0;
  localparam logic [17:0] C_FETCH    = 18'b1_0_0_1_0_1_0_0_0_0_01_00_00_0_0;
  localparam logic [17:0] C_FETCH_W  = 18'b0_0_0_1_0_0_0_0_0_0_01_00_00_0_0;
  localparam logic [17:0] C_DECODE   = 18'b0_0_0_0_0_0_0_0_0_0_11_00_00_0_0;
  localparam logic [17:0] C_DEC_ILL  = 18'b0_0_0_0_0_0_0_0_0_0_11_00_00_0_1;
  localparam logic [17:0] C_MEMADR   = 18'b0_0_0_0_0_0_0_0_0_1_10_00_00_0_0;
  localparam logic [17:0] C_MEMRD    = 18'b0_0_1_1_0_0_0_0_0_0_00_00_00_0_0;
  localparam logic [17:0] C_MEMWB    = 18'b0_0_0_0_0_0_1_1_0_0_00_00_00_1_0;
  localparam logic [17:0] C_MEMWR    = 18'b0_0_1_0_1_0_0_0_0_0_00_00_00_1_0;
  localparam logic [17:0] C_RTYPE_EX = 18'b0_0_0_0_0_0_0_0_0_1_00_00_10_0_0;
  localparam logic [17:0] C_RTYPE_WB = 18'b0_0_0_0_0_0_0_1_1_0_00_00_00_1_0;
  localparam logic [17:0] C_BEQ_EX   = 18'b0_1_0_0_0_0_0_0_0_1_00_01_01_1_0;
  localparam logic [17:0] C_ADDI_EX  = 18'b0_0_0_0_0_0_0_0_0_1_10_00_00_0_0;
  localparam logic [17:0] C_ADDI_WB  = 18'b0_0_0_0_0_0_0_1_0_0_00_00_00_1_0;
  localparam logic [17:0] C_JUMP     = 18'b1_0_0_0_0_0_0_0_0_0_00_10_00_1_0;

  localparam logic [3:0] ST_FETCH = 4'd0, ST_DECODE = 4'd1, ST_MEMADR = 4'd2, ST_MEMRD = 4'd3;
  localparam logic [3:0] ST_MEMWB = 4'd4, ST_MEMWR = 4'd5, ST_RTYPE_EX = 4'd6, ST_RTYPE_WB = 4'd7;
  localparam logic [3:0] ST_BEQ_EX = 4'd8, ST_ADDI_EX = 4'd9, ST_ADDI_WB = 4'd10, ST_JUMP = 4'd11;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_cyc(input string tag, input logic [3:0] st, input logic [17:0] c);
    chk({tag, "/state"}, 32'(oState), 32'(st));
    chk({tag, "/ctrl"}, 32'(ctrl_obs), 32'(c));
    if (oInstrDone === 1'b1) done_cnt++;
  endtask

  task automatic tick;
    @(posedge iClk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    iReset  = 1'b1;
    iOpcode = OP_LW;
`ifdef MEM_WAIT_EN
    iMemReady = 1'b1;
`endif
    repeat (3) tick;
    expect_cyc("reset", ST_FETCH, C_ZERO);

    // lw: 5 cycles, Done exactly once
    iReset = 1'b0;
    #1;
    done_cnt = 0;
    expect_cyc("lw_fetch", ST_FETCH, C_FETCH);    tick;
    expect_cyc("lw_decode", ST_DECODE, C_DECODE); tick;
    expect_cyc("lw_memadr", ST_MEMADR, C_MEMADR); tick;
    expect_cyc("lw_memrd", ST_MEMRD, C_MEMRD);    tick;
    expect_cyc("lw_memwb", ST_MEMWB, C_MEMWB);    tick;
    chk("lw_done_once", 32'(done_cnt), 32'd1);

    // sw: 4 cycles; opcode change after DECODE must not redirect to MEMRD
    iOpcode = OP_SW;
    expect_cyc("sw_fetch", ST_FETCH, C_FETCH);    tick;
    expect_cyc("sw_decode", ST_DECODE, C_DECODE); tick;
    iOpcode = OP_LW;
    #1;
    expect_cyc("sw_memadr", ST_MEMADR, C_MEMADR); tick;
    expect_cyc("sw_memwr", ST_MEMWR, C_MEMWR);    tick;

    // R-type: 4 cycles
    iOpcode = OP_RTYPE;
    expect_cyc("r_fetch", ST_FETCH, C_FETCH);       tick;
    expect_cyc("r_decode", ST_DECODE, C_DECODE);    tick;
    expect_cyc("r_ex", ST_RTYPE_EX, C_RTYPE_EX);    tick;
    expect_cyc("r_wb", ST_RTYPE_WB, C_RTYPE_WB);    tick;

    // beq: 3 cycles, back to FETCH in cycle 4
    iOpcode = OP_BEQ;
    expect_cyc("beq_fetch", ST_FETCH, C_FETCH);    tick;
    expect_cyc("beq_decode", ST_DECODE, C_DECODE); tick;
    expect_cyc("beq_ex", ST_BEQ_EX, C_BEQ_EX);     tick;

    // addi: 4 cycles
    iOpcode = OP_ADDI;
    expect_cyc("addi_fetch", ST_FETCH, C_FETCH);    tick;
    expect_cyc("addi_decode", ST_DECODE, C_DECODE); tick;
    expect_cyc("addi_ex", ST_ADDI_EX, C_ADDI_EX);   tick;
    expect_cyc("addi_wb", ST_ADDI_WB, C_ADDI_WB);   tick;

    // j: 3 cycles
    iOpcode = OP_J;
    expect_cyc("j_fetch", ST_FETCH, C_FETCH);    tick;
    expect_cyc("j_decode", ST_DECODE, C_DECODE); tick;
    expect_cyc("j_jump", ST_JUMP, C_JUMP);       tick;

    // illegal opcode: oIllegal only in DECODE, then FETCH
    iOpcode = 6'h3F;
    done_cnt = 0;
    expect_cyc("ill_fetch", ST_FETCH, C_FETCH);     tick;
    expect_cyc("ill_decode", ST_DECODE, C_DEC_ILL); tick;
    expect_cyc("ill_refetch", ST_FETCH, C_FETCH);
    chk("ill_no_done", 32'(done_cnt), 32'd0);
    tick;
    expect_cyc("ill_after_decode", ST_DECODE, C_DEC_ILL); tick;

    // reset during MEMRD of lw aborts it: no MEMWB, no RegWrite
    iOpcode = OP_LW;
    expect_cyc("ab_fetch", ST_FETCH, C_FETCH);    tick;
    expect_cyc("ab_decode", ST_DECODE, C_DECODE); tick;
    expect_cyc("ab_memadr", ST_MEMADR, C_MEMADR); tick;
    expect_cyc("ab_memrd", ST_MEMRD, C_MEMRD);
    iReset = 1'b1;
    #1;
    expect_cyc("ab_memrd_rst", ST_MEMRD, C_ZERO); tick;
    expect_cyc("ab_rst_fetch", ST_FETCH, C_ZERO);
    iReset  = 1'b0;
    iOpcode = OP_RTYPE;
    #1;
    expect_cyc("ab_rel_fetch", ST_FETCH, C_FETCH);  tick;
    expect_cyc("ab_rel_decode", ST_DECODE, C_DECODE); tick;
    expect_cyc("ab_rel_rex", ST_RTYPE_EX, C_RTYPE_EX); tick;
    expect_cyc("ab_rel_rwb", ST_RTYPE_WB, C_RTYPE_WB); tick;

`ifdef MEM_WAIT_EN
    // FETCH holds 3 cycles while memory is not ready
    iMemReady = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      expect_cyc("mw_hold", ST_FETCH, C_FETCH_W);
      tick;
    end
    iMemReady = 1'b1;
    #1;
    expect_cyc("mw_ready", ST_FETCH, C_FETCH); tick;
    expect_cyc("mw_decode", ST_DECODE, C_DECODE); tick;
    expect_cyc("mw_rex", ST_RTYPE_EX, C_RTYPE_EX); tick;
    expect_cyc("mw_rwb", ST_RTYPE_WB, C_RTYPE_WB); tick;

    // 15 hold cycles -> sticky timeout
    iMemReady = 1'b0;
    #1;
    repeat (14) tick;
    chk("mw_to_before", 32'(oMemTimeout), 32'd0);
    tick;
    chk("mw_to_set", 32'(oMemTimeout), 32'd1);
    expect_cyc("mw_to_fetch", ST_FETCH, C_FETCH_W);
    iMemReady = 1'b1;
    tick;
    tick;
    chk("mw_to_sticky", 32'(oMemTimeout), 32'd1);
    iReset = 1'b1;
    tick;
    chk("mw_to_rst", 32'(oMemTimeout), 32'd0);
    iReset = 1'b0;
    tick;
    chk("mw_to_cleared", 32'(oMemTimeout), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
